snn_input_sequencer: RTL
========================

Name: snn_input_sequencer

Overview:
- Fetch controller for the 784-pixel, 1-bit-per-pixel input-image ROM (10-bit address, registered read, 1-cycle latency).
- On `start`, walks ROM addresses 0..NUM_PIXELS-1 and streams each pixel to the first SNN layer over a valid/ready handshake.
- Absorbs the ROM read latency and downstream backpressure with a 2-entry buffer; no pixel is lost or duplicated.
- Signals `busy` and `done` to the top-level network controller.

Parameters:
- NUM_PIXELS, 784, number of pixels per image (28x28).
- ADDR_W, 10, ROM address width; NUM_PIXELS <= 2**ADDR_W required.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin one image pass; sampled only in IDLE.
- abort  input  1  synchronous flush back to IDLE; highest priority after reset.
- rom_addr  output  ADDR_W  address driven to input ROM.
- rom_q  input  1  ROM data, valid one clock after rom_addr is sampled.
- pix_valid  output  1  head pixel available.
- pix_ready  input  1  downstream accepts head pixel.
- pix_data  output  1  head pixel value.
- pix_idx  output  ADDR_W  pixel index of head pixel.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse, pass complete.

Behaviour:
- Reset: all outputs 0, rom_addr=0, FIFO empty, inflight=0, state IDLE.
- Handshake:
  - pop = pix_valid & pix_ready.
  - While pix_valid=1 and pix_ready=0, pix_data and pix_idx hold stable.
- States and transitions:
  - IDLE: start=1 -> FETCH, busy<=1, issue counter=0, out counter=0.
  - FETCH: issue a read when (fifo_count + inflight - pop) <= 1. Issue = drive rom_addr=issue counter this cycle, set inflight<=1, increment issue counter. When the issue counter reaches NUM_PIXELS-1 and that address issues -> DRAIN.
  - DRAIN: no new issues; wait for the handshake of the pixel with pix_idx=NUM_PIXELS-1 -> DONE.
  - DONE: done=1 and busy<=0 for exactly one cycle -> IDLE.
- Read accounting:
  - inflight=1 means rom_q at the current edge belongs to the previously issued address.
  - At that edge the value is pushed into the FIFO; inflight clears unless a new issue occurs in the same cycle.
  - When not issuing, rom_addr holds its last value; reads with inflight=0 are discarded.
- FIFO: 2 entries, 1-bit data. Push and pop in the same cycle are allowed at any occupancy, including full with pop. The credit rule guarantees no push when full without pop; overflow is an assertion failure.
- pix_idx: out counter, increments on pop.
- Latency and throughput:
  - start sampled at edge E0: address 0 presented after E0 and sampled at E1; pushed at E2; pix_valid=1 after E2.
  - With pix_ready held high: one pixel per cycle, 784 consecutive valid cycles.
  - done asserts the cycle after the final handshake.
- Boundaries:
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
  - abort in any state: next cycle IDLE, FIFO flushed, inflight=0, pix_valid=0, busy=0, no done pulse. abort in IDLE is a no-op. abort and start together: abort wins.
  - The issue counter never exceeds NUM_PIXELS-1, so rom_addr never exceeds 783.
  - Reset mid-pass: immediate return to reset values.

Decomposition:
- Shared package/include snn_pkg: NUM_PIXELS, ADDR_W, state encoding (IDLE, FETCH, DRAIN, DONE).
- One sub-module: snn_fifo2, a 2-entry synchronous FIFO with push, pop, data, count, and async active-low reset; reusable for other layer handshakes.

Test Plan:
- ROM = image 1, pix_ready tied 1, start pulse at E0:
  - pix_valid first high after E2; 784 consecutive pixels, idx 0..783, data matching the ROM model.
  - done pulses at the cycle after idx 783; busy falls with it.
- pix_ready low for 5 cycles when idx=100:
  - pix_data and pix_idx stable at 100.
  - fifo_count<=2, no rom_addr advance beyond 102.
  - Resumes with no gaps or duplicates; total 784 pixels.
- Random pix_ready (50%), 3 back-to-back passes:
  - Scoreboard exact against the ROM model; no overflow assertion; rom_addr always <= 783.
- start re-pulsed at idx 400 -> ignored; pass completes normally with a single done.
- abort at idx 300, then start 3 cycles later:
  - After abort: pix_valid=0 and busy=0 next cycle, no done.
  - After start: new pass begins at idx 0 and runs to completion.
- rst_n asserted asynchronously mid-pass (idx 500):
  - All outputs 0 immediately.
  - After release, start yields a full correct pass.

Source files
------------

// File: rtl/snn_pkg.sv
// ============================================================================
// Package    : snn_pkg
// Description: Shared constants and state encoding for the SNN input path.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int ADDR_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage : snn_pkg

`default_nettype wire

// File: rtl/snn_fifo2.sv
// ============================================================================
// Module     : snn_fifo2
// Description: Two-entry synchronous FIFO with flush; head entry always at
//              slot 0 so the read data needs no output mux.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_fifo2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop     = pop && (r_count != 2'd0);
  assign head_data = r_mem0;
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (push) begin
            r_mem0  <= push_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, w_pop})
            2'b10: begin
              r_mem1  <= push_data;
              r_count <= 2'd2;
            end
            2'b01: r_count <= 2'd0;
            2'b11: r_mem0  <= push_data;
            default: ;
          endcase
        end
        2'd2: begin
          // Popping from full shifts the tail into the head slot.
          if (w_pop) begin
            r_mem0 <= r_mem1;
            if (push) begin
              r_mem1 <= push_data;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !w_pop && (r_count == 2'd2)));

endmodule : snn_fifo2

`default_nettype wire

// File: rtl/snn_input_sequencer.sv
// ============================================================================
// Module     : snn_input_sequencer
// Description: Walks the input-image ROM once per start and streams pixels
//              to the first SNN layer over valid/ready.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_input_sequencer #(
  parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,
  parameter int ADDR_W     = snn_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_q,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [ADDR_W-1:0] pix_idx,
  output logic              busy,
  output logic              done
);

  import snn_pkg::*;

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

  if (NUM_PIXELS > (1 << ADDR_W)) begin : g_param_check
    $error("snn_input_sequencer: NUM_PIXELS does not fit in ADDR_W");
  end

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_issue_cnt;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [ADDR_W-1:0] r_out_cnt;
  logic              r_inflight;

  logic [1:0]        w_fifo_count;
  logic              w_fifo_data;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_credit_ok;
  logic              w_issue;
  logic              w_start_pass;
  logic              w_last_issue;
  logic              w_last_pop;

  assign w_pop        = pix_valid && pix_ready;
  // Entries held plus the read in flight, less the one leaving this cycle.
  assign w_occ        = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_credit_ok  = (w_occ <= (3'd1 + {2'b00, w_pop}));
  assign w_last_issue = (r_issue_cnt == c_last_idx);
  assign w_last_pop   = w_pop && (r_out_cnt == c_last_idx);

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_start_pass = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_FETCH;
          w_start_pass = 1'b1;
        end
      end
      ST_FETCH: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_last_issue) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_last_pop) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_issue      = 1'b0;
      w_start_pass = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_addr_hold <= '0;
      r_out_cnt   <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr_hold <= r_issue_cnt;
      end
      // The issue counter parks on the last address rather than wrapping.
      if (w_start_pass) begin
        r_issue_cnt <= '0;
      end else if (w_issue && !w_last_issue) begin
        r_issue_cnt <= r_issue_cnt + c_one;
      end
      if (abort || w_start_pass) begin
        r_out_cnt <= '0;
      end else if (w_pop) begin
        r_out_cnt <= r_out_cnt + c_one;
      end
    end
  end

  snn_fifo2 #(
    .WIDTH (1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (r_inflight && !abort),
    .push_data (rom_q),
    .pop       (w_pop),
    .head_data (w_fifo_data),
    .count     (w_fifo_count)
  );

  assign rom_addr  = w_issue ? r_issue_cnt : r_addr_hold;
  assign pix_valid = (w_fifo_count != 2'd0);
  assign pix_data  = w_fifo_data;
  assign pix_idx   = r_out_cnt;
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);

  a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
    rom_addr <= c_last_idx);

endmodule : snn_input_sequencer

`default_nettype wire
